// File: rtl/sar_search.sv
// Successive-approximation search driving an external comparator (g/e/l flags).
// Optional macro SAR_EARLY_EXIT_EN: finish as soon as a valid sample reports e=1.
module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             g,
  input  logic             e,
  input  logic             l,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int unsigned KW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_MAX = KW'(WIDTH - 1);
  localparam logic [KW-1:0] K_ONE = KW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  probe_q, probe_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              found_q, found_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  upd;
  logic              one_hot;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    probe_d  = probe_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    one_hot  = ({g, e, l} == 3'b100) || ({g, e, l} == 3'b010) || ({g, e, l} == 3'b001);
    upd      = probe_q;
    if (l) upd[k_q] = 1'b0;

    unique case (state_q)
      IDLE: begin
        probe_d = '0;
        if (start) begin
          state_d             = SEARCH;
          probe_d             = '0;
          probe_d[WIDTH-1]    = 1'b1;
          k_d                 = K_MAX;
          found_d             = 1'b0;
          err_d               = 1'b0;
        end
      end
      SEARCH: begin
        if (!one_hot) begin
          // Malformed flags: report the probe that was under test, not a partial update.
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = probe_q;
          probe_d  = '0;
          state_d  = DONE;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (e) begin
          result_d = probe_q;
          found_d  = 1'b1;
          probe_d  = '0;
          state_d  = DONE;
        end
`endif
        else if (k_q == '0) begin
          result_d = upd;
          found_d  = 1'b1;
          probe_d  = '0;
          state_d  = DONE;
        end else begin
          probe_d             = upd;
          probe_d[k_q - K_ONE] = 1'b1;
          k_d                 = k_q - K_ONE;
        end
      end
      DONE: begin
        probe_d = '0;
        state_d = IDLE;
      end
      default: begin
        probe_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= K_MAX;
      probe_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign probe  = probe_q;
  assign busy   = (state_q == SEARCH);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (WIDTH=4) with a behavioural comparator on the probe.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       g, e, l;
  logic [3:0] probe, result;
  logic       busy, done, found, err;

  logic [3:0] target;
  logic       force_en, force_g, force_e, force_l;
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  always #5 clk = ~clk;

  assign g = force_en ? force_g : (target > probe);
  assign e = force_en ? force_e : (target == probe);
  assign l = force_en ? force_l : (target < probe);

  sar_search #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .g(g), .e(e), .l(l),
    .probe(probe), .busy(busy), .done(done), .result(result),
    .found(found), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs packed as {busy,done,found,err,result,probe}
  function automatic logic [11:0] outs();
    return {busy, done, found, err, result, probe};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; target = 4'd0;
    force_en = 1'b0; force_g = 1'b0; force_e = 1'b0; force_l = 1'b0;
    step(); step();
    chk("reset_outs", outs(), 12'h000);

    // Target 11: probes 8,12,10,11
    rst = 1'b0; target = 4'd11; start = 1'b1;
    step(); start = 1'b0;
    chk("t11_p0", {busy, probe}, {1'b1, 4'd8});
    step(); chk("t11_p1", probe, 4'd12);
    step(); chk("t11_p2", probe, 4'd10);
    step(); chk("t11_p3", probe, 4'd11);
    step(); chk("t11_done", outs(), {4'b0110, 4'd11, 4'd0});
    step(); chk("t11_idle", outs(), {4'b0010, 4'd11, 4'd0});

    // Target 0: probes 8,4,2,1 -> 0
    target = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    chk("t0_p0", probe, 4'd8);
    step(); chk("t0_p1", probe, 4'd4);
    step(); chk("t0_p2", probe, 4'd2);
    step(); chk("t0_p3", probe, 4'd1);
    step(); chk("t0_done", outs(), {4'b0110, 4'd0, 4'd0});
    step(); chk("t0_idle", {busy, done}, 2'b00);

    // Target 15 with start held high through SEARCH and DONE
    target = 4'd15; start = 1'b1;
    step();
    chk("t15_p0", probe, 4'd8);
    step(); chk("t15_p1", probe, 4'd12);
    step(); chk("t15_p2", probe, 4'd14);
    step(); chk("t15_p3", probe, 4'd15);
    step(); chk("t15_done", outs(), {4'b0110, 4'd15, 4'd0});
    step(); chk("t15_start_in_done_ignored", outs(), {4'b0010, 4'd15, 4'd0});
    start = 1'b0;
    step(); chk("t15_still_idle", outs(), {4'b0010, 4'd15, 4'd0});

    // Target 8: early exit only when the macro is enabled
    target = 4'd8; start = 1'b1;
    step(); start = 1'b0;
    chk("t8_p0", probe, 4'd8);
`ifdef SAR_EARLY_EXIT_EN
    step(); chk("t8_early_done", outs(), {4'b0110, 4'd8, 4'd0});
`else
    step(); chk("t8_p1", probe, 4'd12);
    step(); chk("t8_p2", probe, 4'd10);
    step(); chk("t8_p3", probe, 4'd9);
    step(); chk("t8_done", outs(), {4'b0110, 4'd8, 4'd0});
`endif
    step(); chk("t8_idle", {busy, done}, 2'b00);

    // Invalid flags g=l=1 on the 2nd compare
    target = 4'd11; start = 1'b1;
    step(); start = 1'b0;
    step(); chk("err_p1", probe, 4'd12);
    force_en = 1'b1; force_g = 1'b1; force_e = 1'b0; force_l = 1'b1;
    step(); force_en = 1'b0;
    chk("err_done", outs(), {4'b0101, 4'd12, 4'd0});
    step(); chk("err_idle", outs(), {4'b0001, 4'd12, 4'd0});

    // Reset on the 3rd SEARCH cycle
    target = 4'd11; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk("rst_pre", {busy, probe}, {1'b1, 4'd10});
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("rst_mid", outs(), 12'h000);
    step(); chk("rst_no_done", outs(), 12'h000);

    // Fresh search after the abort
    target = 4'd5; start = 1'b1;
    step(); start = 1'b0;
    chk("t5_p0", probe, 4'd8);
    step(); chk("t5_p1", probe, 4'd4);
    step(); chk("t5_p2", probe, 4'd6);
    step(); chk("t5_p3", probe, 4'd5);
    step(); chk("t5_done", outs(), {4'b0110, 4'd5, 4'd0});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: WIDTH, default 4, operand/probe width in bits (legal 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 g  input  1  external comparator flag: target > probe.
REQ-006 e  input  1  external comparator flag: target == probe.
REQ-007 l  input  1  external comparator flag: target < probe.
REQ-008 probe  output  WIDTH  registered trial value driven to the external comparator's b operand.
REQ-009 busy  output  1  high in SEARCH.
REQ-010 done  output  1  one-cycle pulse, high only in DONE.
REQ-011 result  output  WIDTH  recovered target value; held until the next accepted start.
REQ-012 found  output  1  result valid; held with result.
REQ-013 err  output  1  flags g/e/l were not one-hot during the search; held with result.

Function
REQ-014 States: IDLE, SEARCH, DONE; bit index k counts WIDTH-1 down to 0.
REQ-015 IDLE: probe=0, busy=0, done=0; start=1 -> SEARCH, probe = 1<<(WIDTH-1), k=WIDTH-1, found=0, err=0.
REQ-016 start outside IDLE is ignored, with no effect on probe, k or outputs.
REQ-017 External comparator is combinational; g/e/l are sampled at each SEARCH edge against the current registered probe, one compare per cycle.
REQ-018 SEARCH with g=1 or e=1 keeps probe bit k; with l=1 it clears probe bit k.
REQ-019 SEARCH with k>0: set probe bit k-1, decrement k, stay in SEARCH.
REQ-020 SEARCH with k==0: result = updated probe, found=1, -> DONE.
REQ-021 SEARCH with {g,e,l} not exactly one-hot (000, 011, 101, 110, 111): err=1, found=0, result=current probe, -> DONE immediately.
REQ-022 DONE: done=1, busy=0, probe=0 for exactly one cycle, then -> IDLE unconditionally; start in DONE is ignored.
REQ-023 Latency without early exit: done is high in the cycle after the WIDTH-th edge following the start-sampling edge, for every target value.
REQ-024 Boundaries: target=0 clears every bit, giving result 0; target=2^WIDTH-1 keeps every bit, giving result all ones; no wrap-around is possible.

Reset
REQ-025 rst=1 at any edge, including mid-SEARCH or DONE: state=IDLE, k=WIDTH-1, probe=0, busy=0, done=0, result=0, found=0, err=0.
REQ-026 rst has priority over start and over the g/e/l flags in the same cycle; no done pulse is produced for an aborted search.

Configuration
REQ-027 Macro SAR_EARLY_EXIT_EN defined: a valid flag sample with e=1 in SEARCH sets result=probe and found=1, then -> DONE at that edge, so latency = compares performed.
REQ-028 Macro SAR_EARLY_EXIT_EN undefined: e=1 is treated as "keep bit" only, and the search always performs WIDTH compares.

Verification
REQ-029 WIDTH=4, target 11, macro off: start -> probes 8,12,10,11 on successive cycles; done, found=1, result=11 after the 4th compare edge.
REQ-030 WIDTH=4, target 8, macro on: start -> probe 8, e=1 -> done after 1 compare; result=8, found=1, busy low in the done cycle.
REQ-031 WIDTH=4, targets 0 and 15, macro off: probes 8,4,2,1 give result 0; probes 8,12,14,15 give result 15; each takes 4 compares.
REQ-032 Force g=1 and l=1 on the 2nd compare: err=1, found=0, result=current probe, done pulse one cycle later, then IDLE.
REQ-033 rst=1 on the 3rd SEARCH cycle: all outputs 0 next cycle, state IDLE, no done pulse; a new start then completes normally.
REQ-034 start pulsed during SEARCH and during DONE: ignored; probe sequence and result unchanged, no second search launched.
